// File: rtl/mem_line_responder_pkg.sv
// Shared types and default configuration for the memory line responder.
// The defaults mirror the D-cache micro-architecture configuration.
package mem_line_responder_pkg;

  // Micro-architecture configuration the responder is sized against
  localparam int CONF_DCACHE_LINE_BYTE_NUM = 8;
  localparam int CONF_DCACHE_MSHR_NUM      = 2;
  localparam int CONF_MEM_LINE_NUM         = 4096;

  // Line payload width derived from the line size
  localparam int LINE_DATA_WIDTH = CONF_DCACHE_LINE_BYTE_NUM * 8;

  // Index and tag widths for the default configuration
  localparam int DEFAULT_INDEX_WIDTH = $clog2(CONF_MEM_LINE_NUM);
  localparam int DEFAULT_ID_WIDTH    = (CONF_DCACHE_MSHR_NUM > 1) ?
                                       $clog2(CONF_DCACHE_MSHR_NUM) : 1;

  typedef logic [LINE_DATA_WIDTH-1:0] MemLineData;

  // One buffered request in the default configuration; the top module
  // builds the same layout from its own parameters.
  typedef struct packed {
    logic                           we;
    logic [DEFAULT_INDEX_WIDTH-1:0] index;
    MemLineData                     data;
    logic [DEFAULT_ID_WIDTH-1:0]    id;
  } MemReqPath;

  // Service engine states
  typedef enum logic [1:0] {
    MRS_IDLE,
    MRS_WAIT,
    MRS_RESP
  } MemResponderState;

  // Width needed to count/encode n values, never less than one bit
  function automatic int min1_clog2(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/mem_line_responder_queue.sv
// In-order request buffer for the memory line responder.
// Plain circular FIFO; a full queue never accepts a push, even when a pop
// happens in the same cycle.
module mem_req_queue
  import mem_line_responder_pkg::*;
#(
  parameter int WIDTH = 1,
  parameter int DEPTH = 2
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             push_i,
  input  logic             pop_i,
  input  logic [WIDTH-1:0] wdata_i,
  output logic             full_o,
  output logic             empty_o,
  output logic [WIDTH-1:0] head_o
);

  localparam int PTR_W = min1_clog2(DEPTH);
  localparam int CNT_W = $clog2(DEPTH) + 1;

  logic [WIDTH-1:0] slots_q [DEPTH];
  logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0] count_q, count_d;
  logic             do_push, do_pop;

  // Advance a pointer, wrapping at the queue depth
  function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
    return (p == PTR_W'(DEPTH - 1)) ? '0 : p + PTR_W'(1);
  endfunction

  assign full_o  = (count_q == CNT_W'(DEPTH));
  assign empty_o = (count_q == '0);
  assign head_o  = slots_q[rd_ptr_q];

  assign do_push = push_i & ~full_o;
  assign do_pop  = pop_i & ~empty_o;

  // Next pointer and occupancy; simultaneous push and pop keep the count
  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (do_push) wr_ptr_d = ptr_inc(wr_ptr_q);
    if (do_pop)  rd_ptr_d = ptr_inc(rd_ptr_q);
    case ({do_push, do_pop})
      2'b10:   count_d = count_q + CNT_W'(1);
      2'b01:   count_d = count_q - CNT_W'(1);
      default: count_d = count_q;
    endcase
  end

  // Control state: pointers and count are cleared by reset
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  // Payload storage; contents only matter behind a valid count
  always_ff @(posedge clk) begin
    if (do_push) slots_q[wr_ptr_q] <= wdata_i;
  end

endmodule

// File: rtl/mem_line_responder.sv
// Memory-side line responder: buffers line read/write requests in order,
// serves each one from a local line array after a fixed wait, and returns
// one tagged response per request.
module mem_line_responder
  import mem_line_responder_pkg::*;
#(
  parameter int LINE_BYTE_NUM = CONF_DCACHE_LINE_BYTE_NUM,
  parameter int LINE_NUM      = CONF_MEM_LINE_NUM,
  parameter int ADDR_WIDTH    = 32,
  parameter int ID_NUM        = CONF_DCACHE_MSHR_NUM,
  parameter int LATENCY       = 4
) (
  input  logic                            clk,
  input  logic                            rst,
  input  logic                            req_valid,
  output logic                            req_ready,
  input  logic                            req_we,
  input  logic [ADDR_WIDTH-1:0]           req_addr,
  input  logic [LINE_BYTE_NUM*8-1:0]      req_data,
  input  logic [min1_clog2(ID_NUM)-1:0]   req_id,
  output logic                            rsp_valid,
  input  logic                            rsp_ready,
  output logic                            rsp_we,
  output logic [min1_clog2(ID_NUM)-1:0]   rsp_id,
  output logic [LINE_BYTE_NUM*8-1:0]      rsp_data
);

  localparam int OFFSET = $clog2(LINE_BYTE_NUM);
  localparam int IDX_W  = $clog2(LINE_NUM);
  localparam int ID_W   = min1_clog2(ID_NUM);
  localparam int LINE_W = LINE_BYTE_NUM * 8;
  localparam int LAT_W  = min1_clog2(LATENCY);

  typedef struct packed {
    logic              we;
    logic [IDX_W-1:0]  index;
    logic [LINE_W-1:0] data;
    logic [ID_W-1:0]   id;
  } req_path_t;

  req_path_t        push_path;
  req_path_t        head_path;
  req_path_t        svc_q;
  logic             q_full, q_empty, q_push, q_pop;

  MemResponderState state_q;
  logic [LAT_W-1:0] cnt_q;
  logic             rsp_valid_q;
  logic             rsp_we_q;
  logic [ID_W-1:0]  rsp_id_q;

  logic [LINE_W-1:0] mem_q [LINE_NUM];
  logic [LINE_W-1:0] rdata_q;
  logic              access;

  // Address bits above and below the line index are deliberately dropped
  logic unused_addr;
  assign unused_addr = ^req_addr;

  // Offset bits are ignored and high bits alias modulo the array size
  assign push_path = '{we:    req_we,
                       index: req_addr[OFFSET +: IDX_W],
                       data:  req_data,
                       id:    req_id};

  // Acceptance depends only on occupancy, never on req_valid
  assign req_ready = ~q_full;
  assign q_push    = req_valid & ~q_full;
  assign q_pop     = (state_q == MRS_IDLE) & ~q_empty;

  mem_req_queue #(
    .WIDTH ($bits(req_path_t)),
    .DEPTH (ID_NUM)
  ) u_queue (
    .clk     (clk),
    .rst     (rst),
    .push_i  (q_push),
    .pop_i   (q_pop),
    .wdata_i (push_path),
    .full_o  (q_full),
    .empty_o (q_empty),
    .head_o  (head_path)
  );

  // The array is touched once per request, on the last wait cycle
  assign access = (state_q == MRS_WAIT) && (cnt_q == '0);

  // Service engine: dequeue, wait out the latency, then hold the response
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= MRS_IDLE;
      cnt_q       <= '0;
      rsp_valid_q <= 1'b0;
      rsp_we_q    <= 1'b0;
      rsp_id_q    <= '0;
    end else begin
      case (state_q)
        MRS_IDLE: begin
          if (!q_empty) begin
            cnt_q   <= LAT_W'(LATENCY - 1);
            state_q <= MRS_WAIT;
          end
        end
        MRS_WAIT: begin
          if (cnt_q != '0) begin
            cnt_q <= cnt_q - LAT_W'(1);
          end else begin
            state_q     <= MRS_RESP;
            rsp_valid_q <= 1'b1;
            rsp_we_q    <= svc_q.we;
            rsp_id_q    <= svc_q.id;
          end
        end
        MRS_RESP: begin
          if (rsp_ready) begin
            rsp_valid_q <= 1'b0;
            state_q     <= MRS_IDLE;
          end
        end
        default: state_q <= MRS_IDLE;
      endcase
    end
  end

  // Service register captures the queue head as it is dequeued
  always_ff @(posedge clk) begin
    if (q_pop) svc_q <= head_path;
  end

  // Single-port line array with registered read; survives reset
  always_ff @(posedge clk) begin
    if (access) begin
      if (svc_q.we) mem_q[svc_q.index] <= svc_q.data;
      else          rdata_q            <= mem_q[svc_q.index];
    end
  end

  // Read data is only exposed on a valid read response, else zero
  assign rsp_valid = rsp_valid_q;
  assign rsp_we    = rsp_we_q;
  assign rsp_id    = rsp_id_q;
  assign rsp_data  = (rsp_valid_q && !rsp_we_q) ? rdata_q : '0;

endmodule

// File: tb/tb_mem_line_responder.sv
// Bench for mem_line_responder: directed scenarios plus a randomized run
// against an in-order reference model of the line array.
module tb_mem_line_responder;

  localparam int LAT = 4;

  logic        clk = 1'b0;
  logic        rst;
  logic        req_valid;
  logic        req_ready;
  logic        req_we;
  logic [31:0] req_addr;
  logic [63:0] req_data;
  logic [0:0]  req_id;
  logic        rsp_valid;
  logic        rsp_ready;
  logic        rsp_we;
  logic [0:0]  rsp_id;
  logic [63:0] rsp_data;

  typedef struct packed {
    logic        we;
    logic [0:0]  id;
    logic [63:0] data;
  } rsp_t;

  rsp_t        exp_q [$];
  logic [63:0] model_mem [int];
  int          checks = 0;
  int          passes = 0;

  always #5 clk = ~clk;

  mem_line_responder #(
    .LINE_BYTE_NUM (8),
    .LINE_NUM      (4096),
    .ADDR_WIDTH    (32),
    .ID_NUM        (2),
    .LATENCY       (LAT)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .req_valid (req_valid),
    .req_ready (req_ready),
    .req_we    (req_we),
    .req_addr  (req_addr),
    .req_data  (req_data),
    .req_id    (req_id),
    .rsp_valid (rsp_valid),
    .rsp_ready (rsp_ready),
    .rsp_we    (rsp_we),
    .rsp_id    (rsp_id),
    .rsp_data  (rsp_data)
  );

  function automatic int line_of(input logic [31:0] a);
    return int'((a >> 3) % 32'd4096);
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Present a request until accepted; the model is updated in accept order
  task automatic issue(input logic we, input logic [31:0] addr,
                       input logic [63:0] data, input logic [0:0] id,
                       output bit ok);
    int   l;
    rsp_t e;
    ok        = 1'b0;
    req_valid = 1'b1;
    req_we    = we;
    req_addr  = addr;
    req_data  = data;
    req_id    = id;
    for (int i = 0; i < 200; i++) begin
      if (req_ready) begin
        l    = line_of(addr);
        e.we = we;
        e.id = id;
        if (we) begin
          model_mem[l] = data;
          e.data       = 64'h0;
        end else begin
          e.data = model_mem.exists(l) ? model_mem[l] : 64'hx;
        end
        exp_q.push_back(e);
        tick();
        ok = 1'b1;
        break;
      end
      tick();
    end
    req_valid = 1'b0;
    req_data  = {$urandom, $urandom};
  endtask

  // Wait for a response and take it; leaves rsp_ready low afterwards
  task automatic get_rsp(input int budget, output bit got, output rsp_t r);
    got       = 1'b0;
    r         = '0;
    rsp_ready = 1'b1;
    for (int i = 0; i < budget; i++) begin
      if (rsp_valid) begin
        r.we   = rsp_we;
        r.id   = rsp_id;
        r.data = rsp_data;
        got    = 1'b1;
        tick();
        break;
      end
      tick();
    end
    rsp_ready = 1'b0;
  endtask

  task automatic test_reset();
    req_valid = 1'b0; req_we = 1'b0; req_addr = '0; req_data = '0; req_id = '0;
    rsp_ready = 1'b0;
    rst = 1'b1;
    #2;
    checks++; if (req_ready !== 1'b1) $display("FAIL reset_req_ready: got %b want 1", req_ready); else passes++;
    checks++; if (rsp_valid !== 1'b0) $display("FAIL reset_rsp_valid: got %b want 0", rsp_valid); else passes++;
    checks++; if (rsp_we !== 1'b0) $display("FAIL reset_rsp_we: got %b want 0", rsp_we); else passes++;
    checks++; if (rsp_id !== 1'b0) $display("FAIL reset_rsp_id: got %b want 0", rsp_id); else passes++;
    checks++; if (rsp_data !== 64'h0) $display("FAIL reset_rsp_data: got %h want 0", rsp_data); else passes++;
    tick();
    tick();
    rst = 1'b0;
    tick();
    checks++; if (req_ready !== 1'b1 || rsp_valid !== 1'b0) $display("FAIL post_reset_idle: ready %b valid %b want 1 0", req_ready, rsp_valid); else passes++;
  endtask

  task automatic test_single_read();
    bit   ok, got;
    rsp_t r;
    int   k;
    exp_q.delete();
    issue(1'b1, 32'h18, 64'h1122334455667788, 1'b0, ok);
    get_rsp(50, got, r);
    checks++; if (!got || r.we !== 1'b1 || r.data !== 64'h0 || r.id !== 1'b0) $display("FAIL preload_ack: got we %b id %b data %h want 1 0 0", r.we, r.id, r.data); else passes++;
    issue(1'b0, 32'h18, 64'h0, 1'b1, ok);
    k = 0;
    while (!rsp_valid && k < 20) begin
      tick();
      k++;
    end
    checks++; if (k != LAT + 1) $display("FAIL read_latency: got %0d want %0d", k, LAT + 1); else passes++;
    checks++; if (rsp_data !== 64'h1122334455667788) $display("FAIL single_read_data: got %h want 1122334455667788", rsp_data); else passes++;
    checks++; if (rsp_id !== 1'b1 || rsp_we !== 1'b0) $display("FAIL single_read_tag: got id %b we %b want 1 0", rsp_id, rsp_we); else passes++;
    rsp_ready = 1'b1;
    tick();
    rsp_ready = 1'b0;
    checks++; if (rsp_valid !== 1'b0) $display("FAIL single_read_release: got valid %b want 0", rsp_valid); else passes++;
  endtask

  task automatic test_write_then_read();
    bit   ok, got1, got2;
    rsp_t r1, r2;
    exp_q.delete();
    issue(1'b1, 32'h40, 64'hDEADBEEFCAFEF00D, 1'b0, ok);
    issue(1'b0, 32'h40, 64'h0, 1'b1, ok);
    get_rsp(50, got1, r1);
    get_rsp(50, got2, r2);
    checks++; if (!got1 || r1 !== rsp_t'({1'b1, 1'b0, 64'h0})) $display("FAIL wr_ack: got %h want %h", r1, rsp_t'({1'b1, 1'b0, 64'h0})); else passes++;
    checks++; if (!got2 || r2 !== rsp_t'({1'b0, 1'b1, 64'hDEADBEEFCAFEF00D})) $display("FAIL rd_after_wr: got %h want %h", r2, rsp_t'({1'b0, 1'b1, 64'hDEADBEEFCAFEF00D})); else passes++;
  endtask

  task automatic test_backpressure();
    bit   ok, got;
    rsp_t r, snap, e;
    bit   frozen;
    int   k;
    exp_q.delete();
    rsp_ready = 1'b0;
    issue(1'b0, 32'h18, 64'h0, 1'b0, ok);
    issue(1'b0, 32'h40, 64'h0, 1'b1, ok);
    issue(1'b0, 32'h1C, 64'h0, 1'b0, ok);
    checks++; if (!ok || req_ready !== 1'b0) $display("FAIL queue_full: ok %b ready %b want 1 0", ok, req_ready); else passes++;
    k = 0;
    while (!rsp_valid && k < 20) begin
      tick();
      k++;
    end
    snap = {rsp_we, rsp_id, rsp_data};
    for (int i = 0; i < 10; i++) begin
      tick();
      frozen = rsp_valid === 1'b1 && {rsp_we, rsp_id, rsp_data} === snap && req_ready === 1'b0;
      checks++; if (!frozen) $display("FAIL hold_cycle_%0d: valid %b rsp %h ready %b want 1 %h 0", i, rsp_valid, {rsp_we, rsp_id, rsp_data}, req_ready, snap); else passes++;
    end
    e = exp_q.pop_front();
    checks++; if (snap !== e) $display("FAIL bp_rsp0: got %h want %h", snap, e); else passes++;
    rsp_ready = 1'b1;
    tick();
    rsp_ready = 1'b0;
    checks++; if (req_ready !== 1'b0) $display("FAIL ready_before_pop: got %b want 0", req_ready); else passes++;
    tick();
    checks++; if (req_ready !== 1'b1) $display("FAIL ready_after_pop: got %b want 1", req_ready); else passes++;
    for (int i = 1; i < 3; i++) begin
      get_rsp(50, got, r);
      e = exp_q.pop_front();
      checks++; if (!got || r !== e) $display("FAIL bp_rsp%0d: got %h want %h", i, r, e); else passes++;
    end
  endtask

  task automatic test_alias();
    bit          ok, got1, got2;
    rsp_t        r1, r2;
    logic [63:0] v;
    exp_q.delete();
    v = {$urandom, $urandom};
    issue(1'b1, 32'h0000_0008, v, 1'b0, ok);
    issue(1'b0, 32'h0000_8008, 64'h0, 1'b1, ok);
    get_rsp(50, got1, r1);
    get_rsp(50, got2, r2);
    checks++; if (!got1 || r1.we !== 1'b1) $display("FAIL alias_ack: got we %b want 1", r1.we); else passes++;
    checks++; if (!got2 || r2.data !== v || r2.we !== 1'b0) $display("FAIL alias_read: got %h want %h", r2.data, v); else passes++;
  endtask

  task automatic test_reset_mid();
    bit          ok, got, seen;
    rsp_t        r;
    logic [63:0] v;
    exp_q.delete();
    v = 64'h0F1E2D3C4B5A6978;
    issue(1'b1, 32'h100, v, 1'b1, ok);
    get_rsp(50, got, r);
    rsp_ready = 1'b0;
    issue(1'b0, 32'h100, 64'h0, 1'b0, ok);
    issue(1'b0, 32'h100, 64'h0, 1'b0, ok);
    issue(1'b0, 32'h100, 64'h0, 1'b0, ok);
    checks++; if (req_ready !== 1'b0) $display("FAIL mid_full: got %b want 0", req_ready); else passes++;
    #2;
    rst = 1'b1;
    #1;
    checks++; if (req_ready !== 1'b1) $display("FAIL async_req_ready: got %b want 1", req_ready); else passes++;
    checks++; if (rsp_we !== 1'b0 || rsp_id !== 1'b0 || rsp_valid !== 1'b0 || rsp_data !== 64'h0) $display("FAIL async_rsp: got we %b id %b valid %b data %h want 0 0 0 0", rsp_we, rsp_id, rsp_valid, rsp_data); else passes++;
    tick();
    tick();
    rst = 1'b0;
    exp_q.delete();
    rsp_ready = 1'b1;
    seen = 1'b0;
    for (int i = 0; i < 20; i++) begin
      tick();
      if (rsp_valid !== 1'b0) seen = 1'b1;
    end
    rsp_ready = 1'b0;
    checks++; if (seen) $display("FAIL dropped_rsp: got valid 1 want 0"); else passes++;
    issue(1'b0, 32'h100, 64'h0, 1'b0, ok);
    get_rsp(50, got, r);
    checks++; if (!got || r.data !== v) $display("FAIL array_kept: got %h want %h", r.data, v); else passes++;
  endtask

  task automatic test_throughput();
    int times [$];
    int n_bad;
    exp_q.delete();
    n_bad = 0;
    fork
      begin
        bit ok;
        issue(1'b0, 32'h18,  64'h0, 1'b0, ok);
        issue(1'b0, 32'h40,  64'h0, 1'b1, ok);
        issue(1'b0, 32'h08,  64'h0, 1'b0, ok);
        issue(1'b0, 32'h100, 64'h0, 1'b1, ok);
      end
      begin
        rsp_t e;
        rsp_ready = 1'b1;
        for (int cyc = 0; cyc < 200 && times.size() < 4; cyc++) begin
          if (rsp_valid) begin
            e = (exp_q.size() > 0) ? exp_q.pop_front() : 'x;
            if ({rsp_we, rsp_id, rsp_data} !== e) n_bad++;
            times.push_back(cyc);
          end
          tick();
        end
        rsp_ready = 1'b0;
      end
    join
    checks++; if (times.size() != 4 || n_bad != 0) $display("FAIL tput_rsps: got %0d rsps %0d wrong want 4 0", times.size(), n_bad); else passes++;
    for (int i = 1; i < times.size(); i++) begin
      checks++; if (times[i] - times[i-1] != LAT + 2) $display("FAIL tput_gap_%0d: got %0d want %0d", i, times[i] - times[i-1], LAT + 2); else passes++;
    end
  endtask

  task automatic test_random();
    localparam int NW = 8;
    localparam int NR = 40;
    int got_n;
    exp_q.delete();
    got_n = 0;
    fork
      begin
        bit ok;
        for (int i = 0; i < NW + NR; i++) begin
          logic [31:0] a;
          logic        we;
          we = (i < NW) ? 1'b1 : ($urandom_range(0, 3) == 0);
          a  = 32'h200 + 32'($urandom_range(0, NW - 1) * 8) + 32'($urandom_range(0, 7));
          if (i < NW) a = 32'h200 + 32'(i * 8);
          else if ($urandom_range(0, 1) == 1) a = a + 32'h8000;
          issue(we, a, {$urandom, $urandom}, 1'($urandom_range(0, 1)), ok);
          repeat ($urandom_range(0, 3)) tick();
        end
      end
      begin
        rsp_t e;
        for (int cyc = 0; cyc < 4000 && got_n < NW + NR; cyc++) begin
          rsp_ready = ($urandom_range(0, 2) != 0);
          if (rsp_valid && rsp_ready) begin
            e = (exp_q.size() > 0) ? exp_q.pop_front() : 'x;
            checks++; if ({rsp_we, rsp_id, rsp_data} !== e) $display("FAIL rand_rsp_%0d: got %h want %h", got_n, {rsp_we, rsp_id, rsp_data}, e); else passes++;
            got_n++;
          end
          tick();
        end
        rsp_ready = 1'b0;
      end
    join
    checks++; if (got_n != NW + NR || exp_q.size() != 0) $display("FAIL rand_count: got %0d left %0d want %0d 0", got_n, exp_q.size(), NW + NR); else passes++;
  endtask

  initial begin
    test_reset();
    test_single_read();
    test_write_then_read();
    test_backpressure();
    test_alias();
    test_reset_mid();
    test_throughput();
    test_random();
    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: got timeout want completion");
    $fatal(1, "simulation time limit");
  end

endmodule
